keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_TICKS, default 4, the number of consecutive stable scan ticks needed to accept a press or a release (legal range 1..15).
REQ-002 system_clock  input  1  single clock for all sequential logic.
REQ-003 cpu_rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 clock_enable  input  1  scan-tick strobe, one system_clock wide; all scan/FSM advancement occurs only on cycles where it is 1.
REQ-005 row_in  input  4  keypad rows, active-low, asynchronous to system_clock.
REQ-006 col_out  output  4  keypad column drive, active-low one-cold (exactly one bit 0).
REQ-007 key_code  output  4  hex code of the last accepted key, equal to row_index*4 + col_index.
REQ-008 key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 key_pressed  output  1  level, high while an accepted key is held.

Function
REQ-010 row_in SHALL pass through a 2-flop synchronizer clocked every system_clock cycle, independent of clock_enable; the FSM SHALL use only the synchronized value.
REQ-011 The FSM SHALL have the states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-012 SCAN: on each tick with synchronized rows == 4'b1111, col_out SHALL rotate 1110->1101->1011->0111->1110 (col_index 0->1->2->3->0).
REQ-013 SCAN: on a tick with any synchronized row low, the block SHALL capture col_index and the row pattern, hold col_out, set the stable count to 1, and go to DEBOUNCE.
REQ-014 If more than one row is low, the lowest row index SHALL win for row_index.
REQ-015 DEBOUNCE: on each tick with the pattern equal to the captured pattern, the count SHALL increment; a differing pattern SHALL return the FSM to SCAN, advance col_out to the next column, and produce no key_valid.
REQ-016 When the count reaches DEBOUNCE_TICKS, key_code SHALL update and key_valid SHALL be 1 for exactly the next system_clock cycle; the FSM SHALL enter HELD and key_pressed SHALL go to 1 in that same cycle.
REQ-017 With DEBOUNCE_TICKS=1, acceptance SHALL occur on the detecting tick itself (SCAN to HELD through DEBOUNCE without extra ticks).
REQ-018 HELD: col_out SHALL stay frozen; a tick with rows == 1111 SHALL move the FSM to RELEASE with the count set to 1; otherwise it SHALL stay in HELD.
REQ-019 RELEASE: ticks with rows == 1111 SHALL increment the count, and any low row SHALL return the FSM to HELD with no new key_valid; on reaching DEBOUNCE_TICKS, key_pressed SHALL clear, the FSM SHALL go to SCAN, and col_out SHALL advance to the next column.
REQ-020 Only one key_valid SHALL be issued per press-hold-release sequence, regardless of hold length or bounces.
REQ-021 key_code SHALL hold its value until the next acceptance.
REQ-022 With clock_enable held at 0, col_out, the state and the count SHALL be frozen; the synchronizer SHALL continue to sample.
REQ-023 With clock_enable held at 1, the block SHALL treat every clock as a tick.
REQ-024 The debounce counter SHALL be 4 bits and SHALL never wrap; it SHALL saturate at DEBOUNCE_TICKS.

Reset
REQ-025 While cpu_rst_n=0, the block SHALL immediately force col_out=4'b1110, key_code=4'h0, key_valid=0, key_pressed=0, state=SCAN, count=0, and synchronizer flops=4'b1111.
REQ-026 Reset asserted in any state, including mid-DEBOUNCE or HELD, SHALL abort the operation with no key_valid emitted; after release the block SHALL resume scanning from column 0 on the first tick.

Verification
REQ-027 Reset/idle: after reset, rows 1111, clock_enable pulsed every 4 clocks -> col_out cycles 1110,1101,1011,0111,1110; key_valid stays 0.
REQ-028 Clean press: row2 held low while col1 is driven, for 10 ticks, then released for 10 ticks -> exactly one key_valid with key_code=4'h9; key_pressed high from acceptance until 4 ticks after release.
REQ-029 Press bounce: DEBOUNCE_TICKS=4, row0 low on col3 for 2 ticks, then 1111 -> no key_valid, key_pressed=0, col_out advances to 1110.
REQ-030 Multi-row: row1 and row3 low together on col3, stable -> key_code=4'h7.
REQ-031 Release bounce: key accepted, then rows alternate 1111/low every 2 ticks for 20 ticks, then stable 1111 -> no second key_valid; key_pressed clears 4 ticks after the final release.
REQ-032 Reset mid-operation: cpu_rst_n pulsed low in HELD -> outputs match REQ-025 within the same cycle, asynchronously; clock_enable held at 0 for 50 clocks -> col_out unchanged.

Source files
------------

// File: rtl/keypad_scanner.sv
// Purpose : 4x4 matrix keypad scanner with debounced press and release detection.
// Latency : rows pass a 2-flop synchronizer; a key is accepted on the DEBOUNCE_TICKS-th stable tick, key_valid the cycle after.
// Backpressure: none; key_valid is a one-cycle pulse that is not held for a consumer.
//
// Ports:
//   system_clock  - single clock
//   cpu_rst_n     - asynchronous active-low reset
//   clock_enable  - scan-tick strobe; the FSM only advances when it is 1
//   row_in[3:0]   - keypad rows, active-low, asynchronous
//   col_out[3:0]  - column drive, active-low one-cold
//   key_code[3:0] - row_index*4 + col_index of the last accepted key
//   key_valid     - one-cycle pulse on acceptance
//   key_pressed   - high while an accepted key is held
module keypad_scanner #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       system_clock,
    input  logic       cpu_rst_n,
    input  logic       clock_enable,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam logic [3:0] DB_TICKS = 4'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] row_meta, row_sync;
    logic [1:0] col_idx, col_idx_nxt;
    logic [3:0] pat, pat_nxt;
    logic [3:0] cnt, cnt_nxt, cnt_inc;
    logic [3:0] key_code_nxt;
    logic       key_valid_nxt, key_pressed_nxt;
    logic       rows_idle;
    logic [1:0] row_idx;
    logic       accept, release_done;

    // Synchronizer runs every clock regardless of the scan tick.
    always_ff @(posedge system_clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    assign rows_idle = (row_sync == 4'b1111);
    assign col_out   = ~(4'b0001 << col_idx);

    // Saturating increment: the count never passes DEBOUNCE_TICKS.
    assign cnt_inc = (cnt < DB_TICKS) ? cnt + 4'd1 : cnt;

    // Acceptance only happens while row_sync equals the captured pattern,
    // so the row index can be taken straight from row_sync. Lowest row wins.
    always_comb begin
        row_idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync[r]) row_idx = 2'(r);
        end
    end

    always_comb begin
        state_nxt       = state;
        col_idx_nxt     = col_idx;
        pat_nxt         = pat;
        cnt_nxt         = cnt;
        key_code_nxt    = key_code;
        key_valid_nxt   = 1'b0;
        key_pressed_nxt = key_pressed;
        accept          = 1'b0;
        release_done    = 1'b0;

        if (clock_enable) begin
            case (state)
                SCAN: begin
                    if (rows_idle) begin
                        col_idx_nxt = col_idx + 2'd1;
                    end else begin
                        pat_nxt = row_sync;
                        cnt_nxt = 4'd1;
                        // A single-tick debounce accepts on the detecting tick.
                        if (DB_TICKS == 4'd1) accept = 1'b1;
                        else                  state_nxt = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (row_sync == pat) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc >= DB_TICKS) accept = 1'b1;
                    end else begin
                        state_nxt   = SCAN;
                        col_idx_nxt = col_idx + 2'd1;
                    end
                end
                HELD: begin
                    if (rows_idle) begin
                        cnt_nxt = 4'd1;
                        if (DB_TICKS == 4'd1) release_done = 1'b1;
                        else                  state_nxt = RELEASE;
                    end
                end
                RELEASE: begin
                    if (rows_idle) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc >= DB_TICKS) release_done = 1'b1;
                    end else begin
                        state_nxt = HELD;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end

        if (accept) begin
            key_code_nxt    = {row_idx, col_idx};
            key_valid_nxt   = 1'b1;
            key_pressed_nxt = 1'b1;
            state_nxt       = HELD;
        end
        if (release_done) begin
            key_pressed_nxt = 1'b0;
            state_nxt       = SCAN;
            col_idx_nxt     = col_idx + 2'd1;
        end
    end

    always_ff @(posedge system_clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state       <= SCAN;
            col_idx     <= 2'd0;
            pat         <= 4'b1111;
            cnt         <= 4'd0;
            key_code    <= 4'h0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
        end else begin
            state       <= state_nxt;
            col_idx     <= col_idx_nxt;
            pat         <= pat_nxt;
            cnt         <= cnt_nxt;
            key_code    <= key_code_nxt;
            key_valid   <= key_valid_nxt;
            key_pressed <= key_pressed_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: two instances (DEBOUNCE_TICKS 4 and 1) share stimulus;
// every clock is compared against a tick-level behavioural keypad model,
// with directed scenarios followed by randomized row patterns and tick strobes.
module tb_keypad_scanner;

    localparam int IDLE    = 0;
    localparam int CONFIRM = 1;
    localparam int DOWN    = 2;
    localparam int LIFT    = 3;

    logic       system_clock = 1'b0;
    logic       cpu_rst_n;
    logic       clock_enable;
    logic [3:0] row_in;
    logic [3:0] col_out_a, key_code_a, col_out_b, key_code_b;
    logic       key_valid_a, key_pressed_a, key_valid_b, key_pressed_b;

    int n_cmp = 0;
    int n_err = 0;
    int vc_a  = 0;
    int vc_b  = 0;

    // Reference model state, index 0 -> 4-tick instance, 1 -> 1-tick instance.
    int         m_col[2];
    int         m_ph[2];
    int         m_cnt[2];
    logic [3:0] m_pat[2];
    logic [3:0] m_code[2];
    logic       m_valid[2];
    logic       m_pressed[2];
    logic [3:0] m_s1, m_s2;

    always #5 system_clock = ~system_clock;

    keypad_scanner #(.DEBOUNCE_TICKS(4)) dut_a (
        .system_clock (system_clock),
        .cpu_rst_n    (cpu_rst_n),
        .clock_enable (clock_enable),
        .row_in       (row_in),
        .col_out      (col_out_a),
        .key_code     (key_code_a),
        .key_valid    (key_valid_a),
        .key_pressed  (key_pressed_a)
    );

    keypad_scanner #(.DEBOUNCE_TICKS(1)) dut_b (
        .system_clock (system_clock),
        .cpu_rst_n    (cpu_rst_n),
        .clock_enable (clock_enable),
        .row_in       (row_in),
        .col_out      (col_out_b),
        .key_code     (key_code_b),
        .key_valid    (key_valid_b),
        .key_pressed  (key_pressed_b)
    );

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] col_drive(input int c);
        logic [3:0] v;
        v    = 4'b1111;
        v[c] = 1'b0;
        return v;
    endfunction

    function automatic int lowest_row(input logic [3:0] rows);
        for (int r = 0; r < 4; r++) if (!rows[r]) return r;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_col[i] = 0; m_ph[i] = IDLE; m_cnt[i] = 0; m_pat[i] = 4'hF;
            m_code[i] = 4'h0; m_valid[i] = 1'b0; m_pressed[i] = 1'b0;
        end
        m_s1 = 4'hF;
        m_s2 = 4'hF;
    endtask

    task automatic model_accept(input int i);
        m_code[i]    = 4'(lowest_row(m_pat[i]) * 4 + m_col[i]);
        m_valid[i]   = 1'b1;
        m_pressed[i] = 1'b1;
        m_ph[i]      = DOWN;
    endtask

    task automatic model_lifted(input int i);
        m_pressed[i] = 1'b0;
        m_ph[i]      = IDLE;
        m_col[i]     = (m_col[i] + 1) % 4;
    endtask

    // One scan tick as seen by keypad instance i with debounce length n.
    task automatic model_tick(input int i, input logic [3:0] rows);
        int n;
        bit any_low;
        n       = (i == 0) ? 4 : 1;
        any_low = (rows != 4'hF);
        case (m_ph[i])
            IDLE: begin
                if (!any_low) m_col[i] = (m_col[i] + 1) % 4;
                else begin
                    m_pat[i] = rows;
                    m_cnt[i] = 1;
                    if (m_cnt[i] >= n) model_accept(i);
                    else m_ph[i] = CONFIRM;
                end
            end
            CONFIRM: begin
                if (rows == m_pat[i]) begin
                    if (m_cnt[i] < n) m_cnt[i]++;
                    if (m_cnt[i] >= n) model_accept(i);
                end else begin
                    m_ph[i]  = IDLE;
                    m_col[i] = (m_col[i] + 1) % 4;
                end
            end
            DOWN: begin
                if (!any_low) begin
                    m_cnt[i] = 1;
                    if (m_cnt[i] >= n) model_lifted(i);
                    else m_ph[i] = LIFT;
                end
            end
            default: begin
                if (!any_low) begin
                    if (m_cnt[i] < n) m_cnt[i]++;
                    if (m_cnt[i] >= n) model_lifted(i);
                end else m_ph[i] = DOWN;
            end
        endcase
    endtask

    // One system clock: drive at negedge, model the edge, compare 1ns after it.
    task automatic clk_step(input logic [3:0] rows, input logic ce);
        @(negedge system_clock);
        row_in       = rows;
        clock_enable = ce;
        @(posedge system_clock);
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            if (ce) model_tick(i, m_s2);
        end
        m_s2 = m_s1;
        m_s1 = rows;
        #1;
        if (key_valid_a === 1'b1) vc_a++;
        if (key_valid_b === 1'b1) vc_b++;
        chk4("a_col_out",     col_out_a,     col_drive(m_col[0]));
        chk4("a_key_code",    key_code_a,    m_code[0]);
        chk1("a_key_valid",   key_valid_a,   m_valid[0]);
        chk1("a_key_pressed", key_pressed_a, m_pressed[0]);
        chk4("b_col_out",     col_out_b,     col_drive(m_col[1]));
        chk4("b_key_code",    key_code_b,    m_code[1]);
        chk1("b_key_valid",   key_valid_b,   m_valid[1]);
        chk1("b_key_pressed", key_pressed_b, m_pressed[1]);
    endtask

    // n scan ticks, each spaced `period` clocks with the strobe on the last one.
    task automatic ticks(input logic [3:0] rows, input int n, input int period);
        for (int k = 0; k < n; k++)
            for (int p = 0; p < period; p++)
                clk_step(rows, (p == period - 1));
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge system_clock);
        clock_enable = 1'b0;
        row_in       = 4'hF;
        #2 cpu_rst_n = 1'b0;
        #1;
        chk4("rst_a_col_out",     col_out_a,     4'b1110);
        chk4("rst_a_key_code",    key_code_a,    4'h0);
        chk1("rst_a_key_valid",   key_valid_a,   1'b0);
        chk1("rst_a_key_pressed", key_pressed_a, 1'b0);
        chk4("rst_b_col_out",     col_out_b,     4'b1110);
        chk4("rst_b_key_code",    key_code_b,    4'h0);
        chk1("rst_b_key_valid",   key_valid_b,   1'b0);
        chk1("rst_b_key_pressed", key_pressed_b, 1'b0);
        model_reset();
        repeat (2) @(posedge system_clock);
        @(negedge system_clock);
        cpu_rst_n = 1'b1;
        vc_a = 0;
        vc_b = 0;
    endtask

    initial begin
        logic [3:0] idle_seq [5];
        logic [3:0] pat;
        int         hold;
        int         sel;
        logic       ce;

        cpu_rst_n    = 1'b1;
        clock_enable = 1'b0;
        row_in       = 4'hF;
        model_reset();

        // Idle rotation with a tick every 4 clocks.
        do_reset();
        idle_seq[0] = 4'b1101; idle_seq[1] = 4'b1011; idle_seq[2] = 4'b0111;
        idle_seq[3] = 4'b1110; idle_seq[4] = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            ticks(4'hF, 1, 4);
            chk4("idle_rotation", col_out_a, idle_seq[k]);
        end
        chkn("idle_no_valid", vc_a, 0);

        // Clean press of row2 on col1, then release.
        ticks(4'b1011, 1, 4);
        chkn("n1_accept_on_detect", vc_b, 1);
        chk4("n1_key_code", key_code_b, 4'h9);
        chkn("press_not_yet", vc_a, 0);
        ticks(4'b1011, 2, 4);
        chk1("press_still_debouncing", key_pressed_a, 1'b0);
        ticks(4'b1011, 1, 4);
        chkn("press_accepted", vc_a, 1);
        chk4("press_key_code", key_code_a, 4'h9);
        chk1("press_pressed", key_pressed_a, 1'b1);
        ticks(4'b1011, 6, 4);
        ticks(4'hF, 3, 4);
        chk1("release_pending", key_pressed_a, 1'b1);
        ticks(4'hF, 1, 4);
        chk1("release_done", key_pressed_a, 1'b0);
        chk4("release_col_adv", col_out_a, 4'b1011);
        ticks(4'hF, 6, 4);
        chkn("press_single_valid", vc_a, 1);
        chk4("code_holds", key_code_a, 4'h9);

        // Press bounce on col3: two low ticks then idle.
        do_reset();
        ticks(4'hF, 3, 4);
        ticks(4'b1110, 2, 4);
        ticks(4'hF, 1, 4);
        chkn("bounce_no_valid", vc_a, 0);
        chk1("bounce_not_pressed", key_pressed_a, 1'b0);
        chk4("bounce_col_adv", col_out_a, 4'b1110);

        // Rows 1 and 3 together on col3: row1 wins.
        do_reset();
        ticks(4'hF, 3, 4);
        ticks(4'b0101, 6, 4);
        chk4("multirow_code", key_code_a, 4'h7);
        chk4("multirow_code_n1", key_code_b, 4'h7);
        chkn("multirow_valid", vc_a, 1);

        // Release bounce: alternate every 2 ticks for 20 ticks, then settle.
        for (int k = 0; k < 5; k++) begin
            ticks(4'hF, 2, 4);
            ticks(4'b0101, 2, 4);
        end
        chk1("relbounce_held", key_pressed_a, 1'b1);
        ticks(4'hF, 3, 4);
        chk1("relbounce_pending", key_pressed_a, 1'b1);
        ticks(4'hF, 1, 4);
        chk1("relbounce_cleared", key_pressed_a, 1'b0);
        chkn("relbounce_one_valid", vc_a, 1);

        // Reset while held, then a frozen stretch with no ticks.
        do_reset();
        ticks(4'hF, 1, 4);
        ticks(4'b1011, 5, 4);
        chk1("held_before_reset", key_pressed_a, 1'b1);
        do_reset();
        for (int k = 0; k < 50; k++) clk_step(4'($urandom_range(0, 15)), 1'b0);
        chk4("frozen_col", col_out_a, 4'b1110);
        chkn("frozen_no_valid", vc_a, 0);
        ticks(4'hF, 1, 4);
        chk4("resume_col1", col_out_a, 4'b1101);

        // Randomized rows and strobes; alternating segments use a tick every clock.
        hold = 0;
        pat  = 4'hF;
        for (int k = 0; k < 4000; k++) begin
            if (hold == 0) begin
                sel = $urandom_range(0, 19);
                pat = 4'hF;
                if (sel >= 17)      pat = 4'($urandom_range(0, 15));
                else if (sel >= 10) pat[$urandom_range(0, 3)] = 1'b0;
                hold = $urandom_range(1, 24);
            end
            hold--;
            if ($urandom_range(0, 999) == 0) do_reset();
            ce = ((k / 500) % 2 == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            clk_step(pat, ce);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
